// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-neuron datapath.
//   - snn_state_e        : accumulator FSM state encoding (ACCUM/DRAIN/FIRE)
//   - SNN_THRESHOLD_DFLT : default firing threshold, 1.0 as IEEE-754 binary32
//   - SNN_BETA_DFLT      : default membrane leak factor, 0.9 as binary32
//   - fp_add/fp_mul/fp_ge: combinational binary32 helpers
// All real-valued quantities travel as 32-bit binary32 (shortreal) bit
// patterns. Helpers round to nearest-even and flush denormals to zero; NaN
// inputs are not expected in this datapath.
// -----------------------------------------------------------------------------
package snn_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      FIRE  = 2'd2
   } snn_state_e;

   localparam logic [31:0] SNN_THRESHOLD_DFLT = 32'h3F80_0000;  // 1.0
   localparam logic [31:0] SNN_BETA_DFLT      = 32'h3F66_6666;  // 0.9
   localparam logic [31:0] SNN_FP_ZERO        = 32'h0000_0000;

   // Round a normalised 27-bit mantissa (hidden bit at [26], guard/round/
   // sticky at [2:0]) and assemble the binary32 word.
   function automatic logic [31:0] fp_pack(input logic s, input int er_in,
                                           input logic [26:0] mn);
      logic [24:0] rnd;
      logic        rup;
      int          er;
      er  = er_in;
      rup = mn[2] & (mn[1] | mn[0] | mn[3]);
      rnd = {1'b0, mn[26:3]} + {24'd0, rup};
      if (rnd[24]) begin
         rnd = rnd >> 1;
         er  = er + 1;
      end
      if (er <= 0)   return {s, 31'd0};
      if (er >= 255) return {s, 8'hFF, 23'd0};
      return {s, 8'(er), rnd[22:0]};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [26:0] mx, my, my_sh, mn;
      logic [27:0] sum;
      logic        sticky;
      int          d, er, msb;
      sticky = 1'b0;
      // x always holds the operand of larger magnitude
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      if (x[30:23] == 8'd0) return '0;
      if (y[30:23] == 8'd0) return x;
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      d  = int'(x[30:23]) - int'(y[30:23]);
      er = int'(x[30:23]);
      if (d > 26) begin
         my_sh = 27'd1;
      end else begin
         for (int unsigned i = 0; i < 27; i++)
            if (int'(i) < d && my[i]) sticky = 1'b1;
         my_sh = (my >> d) | {26'd0, sticky};
      end
      if (x[31] == y[31]) begin
         sum = {1'b0, mx} + {1'b0, my_sh};
         if (sum[27]) begin
            mn = {sum[27:2], sum[1] | sum[0]};
            er = er + 1;
         end else begin
            mn = sum[26:0];
         end
      end else begin
         sum = {1'b0, mx} - {1'b0, my_sh};
         if (sum == '0) return '0;
         msb = 0;
         for (int unsigned i = 0; i < 27; i++)
            if (sum[i]) msb = int'(i);
         mn = sum[26:0] << (26 - msb);
         er = er - (26 - msb);
      end
      return fp_pack(x[31], er, mn);
   endfunction

   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [47:0] p;
      logic [26:0] mn;
      int          er;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
      p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      er = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         mn = {p[47:22], |p[21:0]};
         er = er + 1;
      end else begin
         mn = {p[46:21], |p[20:0]};
      end
      return fp_pack(s, er, mn);
   endfunction

   // a >= b; +0 and -0 compare equal
   function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
      if (a[30:0] == '0 && b[30:0] == '0) return 1'b1;
      if (a[31] != b[31]) return b[31];
      if (!a[31]) return (a[30:0] >= b[30:0]);
      return (a[30:0] <= b[30:0]);
   endfunction

endpackage

// File: rtl/spike_wght_accum.sv
// -----------------------------------------------------------------------------
// spike_wght_accum
// Leaky integrate-and-fire neuron front end. Accepted presynaptic spike events
// fetch a weight from an external weight RAM (one-cycle read latency) and the
// weights are summed per timestep. ts_end closes the timestep: the read
// pipeline is drained, then v = BETA*mem_pot + acc is compared against
// THRESHOLD and the result is reported with a one-cycle out_valid pulse.
//
// Parameters
//   RAM_DEPTH       number of presynaptic inputs / weight words
//   RAM_ADDR_WIDTH  width of spk_idx / w_raddr
//   THRESHOLD, BETA binary32 encodings of firing threshold and leak factor
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   spk_valid/spk_idx/spk_ready  spike event handshake
//   ts_end          single-cycle timestep close pulse (honoured in ACCUM only)
//   w_raddr/w_ren/w_rdat         weight RAM read port (w_rdat one cycle later)
//   out_spike/out_valid          end-of-timestep result (registered)
//   mem_pot         registered membrane potential (binary32)
//   busy            high whenever not in ACCUM
//
// Build option
//   RESET_BY_SUBTRACT_EN  defined: on fire mem_pot <= v - THRESHOLD
//                         undefined: on fire mem_pot <= 0.0
// -----------------------------------------------------------------------------
module spike_wght_accum
   import snn_pkg::*;
#(
   parameter int unsigned RAM_DEPTH      = 32,
   parameter int unsigned RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
   parameter logic [31:0] THRESHOLD      = SNN_THRESHOLD_DFLT,
   parameter logic [31:0] BETA           = SNN_BETA_DFLT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      spk_valid,
   input  logic [RAM_ADDR_WIDTH-1:0] spk_idx,
   output logic                      spk_ready,
   input  logic                      ts_end,
   output logic [RAM_ADDR_WIDTH-1:0] w_raddr,
   output logic                      w_ren,
   input  logic [31:0]               w_rdat,
   output logic                      out_spike,
   output logic                      out_valid,
   output logic [31:0]               mem_pot,
   output logic                      busy
);

   snn_state_e  r_state;
   logic        r_pend;
   logic [31:0] r_acc;
   logic [31:0] r_mem;
   logic        r_spk_ready;
   logic        r_busy;
   logic        r_out_spike;
   logic        r_out_valid;

   logic        w_in_range;
   logic [31:0] w_acc_sum;
   logic [31:0] w_v;
   logic        w_fire;
   logic [31:0] w_mem_fire;

   always_comb begin
      w_in_range = (32'(spk_idx) < RAM_DEPTH);
      // Out-of-range events are still accepted, they just never read.
      w_ren      = spk_valid && r_spk_ready && w_in_range && !rst;
      w_raddr    = spk_idx;
      w_acc_sum  = fp_add(r_acc, w_rdat);
      w_v        = fp_add(fp_mul(BETA, r_mem), r_acc);
      w_fire     = fp_ge(w_v, THRESHOLD);
`ifdef RESET_BY_SUBTRACT_EN
      w_mem_fire = fp_add(w_v, {~THRESHOLD[31], THRESHOLD[30:0]});
`else
      w_mem_fire = SNN_FP_ZERO;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ACCUM;
         r_spk_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_pend      <= 1'b0;
         r_acc       <= SNN_FP_ZERO;
         r_mem       <= SNN_FP_ZERO;
         r_out_spike <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_pend      <= w_ren;
         r_out_spike <= 1'b0;
         r_out_valid <= 1'b0;
         if (r_pend) r_acc <= w_acc_sum;
         case (r_state)
            ACCUM: begin
               if (ts_end) begin
                  r_state     <= DRAIN;
                  r_spk_ready <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end
            DRAIN: begin
               // No reads issue here, so pending clears within one cycle.
               if (!r_pend) r_state <= FIRE;
            end
            FIRE: begin
               // r_pend is always clear here, so this zeroing is not overridden.
               r_acc       <= SNN_FP_ZERO;
               r_mem       <= w_fire ? w_mem_fire : w_v;
               r_out_spike <= w_fire;
               r_out_valid <= 1'b1;
               r_state     <= ACCUM;
               r_spk_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= ACCUM;
               r_spk_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign spk_ready = r_spk_ready;
   assign busy      = r_busy;
   assign out_spike = r_out_spike;
   assign out_valid = r_out_valid;
   assign mem_pot   = r_mem;

endmodule

// File: tb/tb_spike_wght_accum.sv
module tb_spike_wght_accum;

   localparam logic [31:0] W03    = 32'h3E99_999A;  // 0.3
   localparam logic [31:0] W12    = 32'h3F99_999A;  // 1.2
   localparam logic [31:0] W05    = 32'h3F00_0000;  // 0.5
   localparam logic [31:0] POISON = 32'h42C8_0000;  // 100.0, driven when no read is due

   typedef struct {
      logic spike;
      real  mem;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        spk_valid;
   logic [5:0]  spk_idx;
   logic        spk_ready;
   logic        ts_end;
   logic [5:0]  w_raddr;
   logic        w_ren;
   logic [31:0] w_rdat;
   logic        out_spike;
   logic        out_valid;
   logic [31:0] mem_pot;
   logic        busy;

   logic [31:0] w_bits [0:31];
   real         w_real [0:31];
   exp_t        sb [$];
   real         m_acc;
   real         m_mem;
   int          n_vec;
   int          n_err;

   spike_wght_accum #(
      .RAM_DEPTH      (32),
      .RAM_ADDR_WIDTH (6)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .spk_valid (spk_valid),
      .spk_idx   (spk_idx),
      .spk_ready (spk_ready),
      .ts_end    (ts_end),
      .w_raddr   (w_raddr),
      .w_ren     (w_ren),
      .w_rdat    (w_rdat),
      .out_spike (out_spike),
      .out_valid (out_valid),
      .mem_pot   (mem_pot),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Weight RAM: one-cycle read latency
   always @(posedge clk)
      w_rdat <= (w_ren && (w_raddr < 6'd32)) ? w_bits[w_raddr[4:0]] : POISON;

   function automatic real f2r(input logic [31:0] b);
      real m;
      int  e;
      if (b[30:23] == 8'd0) return 0.0;
      m = 1.0 + real'(int'(b[22:0])) / 8388608.0;
      e = int'(b[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e = e - 1; end
      while (e < 0) begin m = m / 2.0; e = e + 1; end
      return b[31] ? -m : m;
   endfunction

   task automatic chk_bit(input string tag, input logic got, input logic exp);
      n_vec = n_vec + 1;
      assert (got === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      assert (got === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_real(input string tag, input logic [31:0] got, input real exp);
      real  diff;
      logic ok;
      diff  = f2r(got) - exp;
      ok    = (diff < 1.0e-5) && (diff > -1.0e-5);
      n_vec = n_vec + 1;
      assert (ok === 1'b1) else begin
         n_err = n_err + 1;
         $error("FAIL %s: got %f (%h) expected %f", tag, f2r(got), got, exp);
      end
   endtask

   // Advance one clock, sample 1 time unit after the edge, score any result.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk_bit("out_valid_idle", out_valid, 1'b0);
         chk_bit("out_spike_idle", out_spike, 1'b0);
      end else if (out_valid) begin
         e = sb.pop_front();
         chk_bit("out_spike", out_spike, e.spike);
         chk_real("mem_pot", mem_pot, e.mem);
      end
   endtask

   // Close the modelled timestep and queue the expected result.
   task automatic push_ts();
      exp_t e;
      real  v;
      v       = 0.9 * m_mem + m_acc;
      e.spike = (v >= 1.0);
`ifdef RESET_BY_SUBTRACT_EN
      m_mem   = e.spike ? v - 1.0 : v;
`else
      m_mem   = e.spike ? 0.0 : v;
`endif
      e.mem   = m_mem;
      m_acc   = 0.0;
      sb.push_back(e);
   endtask

   task automatic send(input int idx, input logic ts);
      spk_valid = 1'b1;
      spk_idx   = 6'(idx);
      ts_end    = ts;
      #1;
      chk_bit("w_ren", w_ren, (idx < 32) ? 1'b1 : 1'b0);
      if (idx < 32) begin
         chk_vec("w_raddr", 32'(w_raddr), 32'(idx));
         m_acc = m_acc + w_real[idx];
      end
      if (ts) push_ts();
      tick();
      spk_valid = 1'b0;
      ts_end    = 1'b0;
   endtask

   task automatic ts_only();
      ts_end = 1'b1;
      push_ts();
      tick();
      ts_end = 1'b0;
   endtask

   // Wait (bounded) for out_valid; the FSM must stay busy/not-ready meanwhile.
   task automatic wait_out();
      logic got;
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         chk_bit("spk_ready_busy", spk_ready, 1'b0);
         chk_bit("busy_high", busy, 1'b1);
         tick();
      end
      chk_bit("out_valid_seen", got, 1'b1);
      chk_bit("spk_ready_back", spk_ready, 1'b1);
      chk_bit("busy_low", busy, 1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_acc = 0.0;
      m_mem = 0.0;
      for (int i = 0; i < 32; i++) begin
         w_bits[i] = W03;
         w_real[i] = 0.3;
      end
      w_bits[5] = W12;  w_real[5] = 1.2;
      w_bits[6] = W05;  w_real[6] = 0.5;

      clk       = 1'b0;
      rst       = 1'b1;
      spk_valid = 1'b1;
      spk_idx   = 6'd0;
      ts_end    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_bit("w_ren_in_rst", w_ren, 1'b0);
      chk_bit("rst_spk_ready", spk_ready, 1'b1);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_out_valid", out_valid, 1'b0);
      chk_bit("rst_out_spike", out_spike, 1'b0);
      chk_vec("rst_mem_pot", mem_pot, 32'h0);
      rst       = 1'b0;
      spk_valid = 1'b0;
      tick();

      // Three 0.3 events back-to-back: mem 0.9, no spike
      send(0, 1'b0);
      send(1, 1'b0);
      send(2, 1'b0);
      ts_only();
      wait_out();

      // Leak then 0.3: v = 1.11, fires
      send(3, 1'b0);
      ts_only();
      wait_out();

      // Event in the ts_end cycle belongs to the closing timestep
      send(5, 1'b1);
      wait_out();

      // Out-of-range index is dropped, in-range one still counts
      send(40, 1'b0);
      send(0, 1'b0);
      ts_only();
      wait_out();

      // Reset one cycle after a read issues: late data must be discarded
      send(5, 1'b0);
      rst       = 1'b1;
      spk_valid = 1'b1;
      spk_idx   = 6'd1;
      #1;
      chk_bit("w_ren_mid_rst", w_ren, 1'b0);
      tick();
      rst       = 1'b0;
      spk_valid = 1'b0;
      m_acc     = 0.0;
      m_mem     = 0.0;
      chk_vec("post_rst_mem_pot", mem_pot, 32'h0);
      chk_bit("post_rst_spk_ready", spk_ready, 1'b1);
      chk_bit("post_rst_busy", busy, 1'b0);
      tick();
      tick();
      ts_only();
      wait_out();

      // Charge to 0.5, then an empty timestep leaks to 0.45;
      // ts_end during DRAIN must not produce a second result
      send(6, 1'b0);
      ts_only();
      wait_out();
      ts_only();
      ts_end = 1'b1;
      tick();
      ts_end = 1'b0;
      wait_out();
      repeat (4) tick();

      chk_bit("scoreboard_empty", (sb.size() == 0) ? 1'b1 : 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
